// File: rtl/arc4_pkg.sv
// arc4_pkg
//   Shared definitions for the ARC4 key-cracking datapath.
//   - PRINT_LO / PRINT_HI : inclusive printable-ASCII window (0x20..0x7E)
//   - pt_check_state_t    : state encoding of the plaintext validator FSM
//   - is_printable()      : 1 when a byte lies inside the printable window
package arc4_pkg;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LEN  = 2'd2,
    ST_CHK  = 2'd3
  } pt_check_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/pt_check.sv
// pt_check
//   Plaintext validator. Streams a length-prefixed plaintext memory
//   (byte 0 = length L, bytes 1..L = message) and reports whether every
//   message byte is printable ASCII. Stops at the first bad byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         start request, sampled only while rdy=1
//   rdy        idle; a new check may be started
//   pt_addr    plaintext memory read address (8 bit, wraps)
//   pt_rddata  plaintext memory read data, one-cycle latency
//   pt_valid   verdict of last completed check (1 = all bytes printable)
//   bad_idx    index of first non-printable byte; only present when
//              the PT_CHECK_DIAG_EN macro is defined
//
// Handshake: a check starts on a rising edge where rdy=1 and en=1. rdy
// drops on the following cycle and rises again in the same cycle that
// pt_valid (and bad_idx) carry the new verdict. en while rdy=0 is dropped.
//
// The current FSM state is held in 'state' (type pt_check_state_t) so
// checkers can bind to it directly.
module pt_check
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       pt_valid
`ifdef PT_CHECK_DIAG_EN
  ,
  output logic [7:0] bad_idx
`endif
);

  pt_check_state_t state;
  logic [7:0]      len;
  logic [7:0]      idx;

  // pt_addr runs one ahead of idx while in CHK, so the byte arriving on
  // pt_rddata always belongs to idx. Prefetches past L are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rdy      <= 1'b1;
      pt_addr  <= 8'd0;
      pt_valid <= 1'b0;
      len      <= 8'd0;
      idx      <= 8'd0;
`ifdef PT_CHECK_DIAG_EN
      bad_idx  <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            pt_addr  <= 8'd0;
            pt_valid <= 1'b0;
`ifdef PT_CHECK_DIAG_EN
            bad_idx  <= 8'd0;
`endif
            rdy      <= 1'b0;
            state    <= ST_RD;
          end
        end

        ST_RD: begin
          // mem[0] is in flight; start fetching the first message byte
          pt_addr <= 8'd1;
          state   <= ST_LEN;
        end

        ST_LEN: begin
          len     <= pt_rddata;
          idx     <= 8'd1;
          pt_addr <= 8'd2;
          if (pt_rddata == 8'd0) begin
            pt_valid <= 1'b1;
            rdy      <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_CHK;
          end
        end

        ST_CHK: begin
          if (!is_printable(pt_rddata)) begin
            pt_valid <= 1'b0;
`ifdef PT_CHECK_DIAG_EN
            bad_idx  <= idx;
`endif
            rdy      <= 1'b1;
            state    <= ST_IDLE;
          end else if (idx == len) begin
            // L=255 finishes here with idx=255, so idx never overflows
            pt_valid <= 1'b1;
            rdy      <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            idx     <= idx + 8'd1;
            pt_addr <= pt_addr + 8'd1;
          end
        end

        default: begin
          rdy   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_check.sv
// tb_pt_check
//   Directed bench for pt_check. A 256-byte memory model with one-cycle
//   read latency feeds the DUT. The driver pushes the hand-computed
//   completion edge and verdict into exp_q at each accepted start; the
//   monitor pops and compares whenever rdy rises. Define PT_CHECK_DIAG_EN
//   to also connect and check bad_idx.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata = 8'd0;
  logic       pt_valid;
`ifdef PT_CHECK_DIAG_EN
  logic [7:0] bad_idx;
`endif

  logic [7:0]  mem [256];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  // {done_edge[15:0], valid, bad_idx[7:0]}
  logic [24:0] exp_q[$];

  pt_check dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .pt_valid  (pt_valid)
`ifdef PT_CHECK_DIAG_EN
    ,
    .bad_idx   (bad_idx)
`endif
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pt_rddata <= mem[pt_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // returns at a falling edge with rdy=1, or flags a timeout
  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got rdy=0 expected rdy=1 within 600 cycles");
    end
  endtask

  task automatic fill_mem(input logic [7:0] len, input logic [7:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
    mem[0] = len;
  endtask

  // lat = edges from accept to verdict
  task automatic start(input int lat, input logic v, input logic [7:0] b, input bit push);
    wait_rdy();
    en = 1'b1;
    if (push) exp_q.push_back({16'(cyc + 1 + lat), v, b});
    @(posedge clk);
    #1;
    en = 1'b0;
    check("rdy_fall", rdy, 1'b0);
    check("valid_clear", pt_valid, 1'b0);
`ifdef PT_CHECK_DIAG_EN
    check("bad_idx_clear", bad_idx, 8'd0);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_rdy = 1'b1;
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b1;
      end else begin
        if (!prev_rdy && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got completion at edge %0d expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_edge", cyc, {16'd0, e[24:9]});
            check("pt_valid", pt_valid, e[8]);
`ifdef PT_CHECK_DIAG_EN
            check("bad_idx", bad_idx, e[7:0]);
`endif
          end
        end
        prev_rdy = rdy;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    fill_mem(8'd0, 8'h41);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_valid", pt_valid, 1'b0);
    check("rst_addr", pt_addr, 8'd0);
`ifdef PT_CHECK_DIAG_EN
    check("rst_bad_idx", bad_idx, 8'd0);
`endif
    #1 rst = 1'b0;

    // L=0: verdict two edges after accept, address sequence 0,1,2
    fill_mem(8'd0, 8'h41);
    start(2, 1'b1, 8'd0, 1'b1);
    check("l0_addr_e0", pt_addr, 8'd0);
    @(posedge clk); #1;
    check("l0_addr_e1", pt_addr, 8'd1);
    @(posedge clk); #1;
    check("l0_addr_e2", pt_addr, 8'd2);
    check("l0_rdy_e2", rdy, 1'b1);

    // "HELLO": passes after 7 edges
    wait_rdy();
    fill_mem(8'd5, 8'h00);
    mem[1] = 8'h48; mem[2] = 8'h45; mem[3] = 8'h4C; mem[4] = 8'h4C; mem[5] = 8'h4F;
    start(7, 1'b1, 8'd0, 1'b1);

    // 0x7F at index 3, bytes 4..5 also bad but must never be reached
    wait_rdy();
    fill_mem(8'd5, 8'h00);
    mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h7F;
    start(5, 1'b0, 8'd3, 1'b1);

    // L=255 all 'A': 257 edges, address wraps to 0 at the end
    wait_rdy();
    fill_mem(8'd255, 8'h41);
    start(257, 1'b1, 8'd0, 1'b1);
    wait_rdy();
    check("l255_addr_wrap", pt_addr, 8'd0);

    // printable boundaries
    fill_mem(8'd2, 8'h00);
    mem[1] = 8'h20; mem[2] = 8'h7E;
    start(4, 1'b1, 8'd0, 1'b1);
    wait_rdy();
    fill_mem(8'd1, 8'h41);
    mem[1] = 8'h1F;
    start(3, 1'b0, 8'd1, 1'b1);
    wait_rdy();
    fill_mem(8'd2, 8'h41);
    mem[2] = 8'h7F;
    start(4, 1'b0, 8'd2, 1'b1);
    wait_rdy();
    fill_mem(8'd3, 8'h41);
    mem[1] = 8'h80;
    start(3, 1'b0, 8'd1, 1'b1);

    // en while busy is dropped, nothing queued
    wait_rdy();
    fill_mem(8'd5, 8'h00);
    mem[1] = 8'h48; mem[2] = 8'h45; mem[3] = 8'h4C; mem[4] = 8'h4C; mem[5] = 8'h4F;
    start(7, 1'b1, 8'd0, 1'b1);
    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_rdy();
    repeat (3) @(negedge clk);
    check("busy_en_ignored", rdy, 1'b1);

    // back-to-back on the same memory: second accept right at rdy
    start(7, 1'b1, 8'd0, 1'b1);
    start(7, 1'b1, 8'd0, 1'b1);

    // reset in the middle of a long check, then a clean run
    wait_rdy();
    fill_mem(8'd255, 8'h41);
    start(257, 1'b1, 8'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", rdy, 1'b1);
    check("midrst_valid", pt_valid, 1'b0);
    check("midrst_addr", pt_addr, 8'd0);
`ifdef PT_CHECK_DIAG_EN
    check("midrst_bad_idx", bad_idx, 8'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    fill_mem(8'd2, 8'h41);
    mem[2] = 8'h0A;
    start(4, 1'b0, 8'd2, 1'b1);

    wait_rdy();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pt_check.md
# pt_check

Plaintext validator for the ARC4 key-cracking datapath. It sits directly upstream of the crack controller's key decision. After a candidate key has decrypted the length-prefixed ciphertext into plaintext memory, this block streams that memory and reports whether every message byte is printable ASCII. The crack controller advances to the next key or asserts key-valid based on this verdict.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  start request; sampled only while `rdy`=1
- `rdy`  out  1  idle/ready; high when a new check may be started
- `pt_addr`  out  8  plaintext memory read address
- `pt_rddata`  in  8  plaintext memory read data; one-cycle latency
- `pt_valid`  out  1  verdict of last completed check; 1 = all message bytes printable
- `bad_idx`  out  8  index of first non-printable byte; present only with `PT_CHECK_DIAG_EN`

## Operation
- Memory format:
  - byte 0 = message length L (0..255)
  - bytes 1..L = plaintext
- Printable range: 0x20..0x7E inclusive. Anything else is bad, including 0x7F and 0x00.
- States: IDLE, RD, LEN, CHK.
  - IDLE: `rdy`=1, outputs hold. `en`=1 → `pt_addr`←0, `pt_valid`←0, `bad_idx`←0, go to RD.
  - RD: `pt_addr`←1, go to LEN.
  - LEN: L←`pt_rddata` (mem[0]), idx←1, `pt_addr`←2.
    - L==0 → `pt_valid`←1, go to IDLE.
    - otherwise → go to CHK.
  - CHK: test `pt_rddata` (= mem[idx]).
    - bad → `pt_valid`←0, `bad_idx`←idx, go to IDLE (early exit).
    - good and idx==L → `pt_valid`←1, go to IDLE.
    - good otherwise → idx←idx+1, `pt_addr`←`pt_addr`+1, stay in CHK.
- `pt_addr` is 8-bit and wraps 255→0. Prefetch reads past L (including the wrap when L=255) are issued but never evaluated.
- idx is 8-bit. L=255 ends with idx==255, so there is no overflow.
- `en` while `rdy`=0 is ignored; there is no queueing.
- `pt_valid` and `bad_idx` hold their value until the next accepted `en`.

## Timing
- Read contract: `pt_rddata` in cycle k equals mem[`pt_addr` in cycle k−1].
- Call the accept edge E0. Verdict and `rdy`=1 are visible after:
  - L==0: edge E0+2
  - all good: edge E0+2+L
  - first bad byte at index i: edge E0+2+i
- `rdy` falls in the cycle after E0. It is high again in the same cycle the verdict becomes valid.
- A new `en` may be accepted on the first edge at which `rdy`=1, back-to-back.
- Reset values: `rdy`=1, `pt_valid`=0, `pt_addr`=0, `bad_idx`=0, state IDLE.
- `rst` mid-check aborts immediately to the reset values. No partial verdict is kept.

## Configuration
- `PT_CHECK_DIAG_EN` defined:
  - adds the `bad_idx` port and its register.
  - `bad_idx` = first offending index on failure, 0 on pass or after reset.
- Undefined:
  - port and register are absent.
  - `pt_valid`, `rdy`, `pt_addr` and all cycle timing are identical.

## Structure
- Shared package `arc4_pkg`:
  - constants `PRINT_LO`=8'h20 and `PRINT_HI`=8'h7E
  - state enum `pt_check_state_t`
  - function `is_printable(byte)`
- No sub-module. Single FSM plus length and index registers. Target 120–200 lines.

## Test plan
- L=0 (mem[0]=0x00), `en` pulse → `pt_valid`=1, `rdy`=1 two edges after accept; `pt_addr` sequence 0,1,2.
- L=5, "HELLO" → `pt_valid`=1 after 7 edges; `bad_idx`=0.
- L=5, mem[3]=0x7F → early exit after 5 edges; `pt_valid`=0, `bad_idx`=3, mem[4..5] never evaluated.
- L=255, all bytes 0x41 → `pt_valid`=1 after 257 edges; `pt_addr` wraps to 0 without error.
- Boundary bytes: 0x20 and 0x7E pass; 0x1F and 0x7F each fail in separate runs.
- `rst` asserted mid-CHK → all outputs at reset values on the same cycle. `en` during busy is ignored. Back-to-back starts on `rdy` both complete correctly.
